unidade_load_store: RTL and testbench

CPU-side initiator for the word-wide data memory (`memoriaDeDados`): accepts load/store requests from the execute stage through a valid/ready handshake and drives the memory's read-enable, write-enable, address and write-data ports. Adds byte and halfword accesses on top of the memory's 32-bit word port: sub-word stores use read-modify-write, and loads return sign- or zero-extended data. Sits between the processor datapath and the data memory.

---
 rtl/unidade_load_store_if.sv | 33 +++
 rtl/unidade_load_store.sv | 133 +++++++++++++
 tb/tb_unidade_load_store.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_load_store_if.sv
// Request/response handshake plus data-memory port bundle for unidade_load_store.
// slave is the load/store unit's view; master is the datapath-plus-memory side.
interface unidade_load_store_if;
    logic        req_valido;
    logic        req_pronto;
    logic        req_escrita;
    logic [1:0]  req_tamanho;
    logic        req_sem_sinal;
    logic [31:0] req_endereco;
    logic [31:0] req_dados;
    logic        resp_valido;
    logic [31:0] resp_dados;
    logic        resp_erro;
    logic        mem_ler;
    logic        mem_escrever;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dados_escrita;
    logic [31:0] mem_dados_lidos;

    modport slave (
        input  req_valido, req_escrita, req_tamanho, req_sem_sinal, req_endereco, req_dados,
        input  mem_dados_lidos,
        output req_pronto, resp_valido, resp_dados, resp_erro,
        output mem_ler, mem_escrever, mem_endereco, mem_dados_escrita
    );

    modport master (
        output req_valido, req_escrita, req_tamanho, req_sem_sinal, req_endereco, req_dados,
        output mem_dados_lidos,
        input  req_pronto, resp_valido, resp_dados, resp_erro,
        input  mem_ler, mem_escrever, mem_endereco, mem_dados_escrita
    );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store initiator for a word-wide data memory: byte/half/word accesses,
// read-modify-write for sub-word stores, sign/zero extension for loads.
module unidade_load_store #(
    parameter int unsigned PALAVRAS = 513
) (
    input logic                 clock,
    input logic                 reset_n,
    unidade_load_store_if.slave bus
);
    typedef enum logic [1:0] {StOcioso, StLeitura, StEscrita, StResposta} estado_e;

    estado_e     estado_q, estado_d;
    logic        escrita_q, escrita_d;
    logic [1:0]  tamanho_q, tamanho_d;
    logic        sem_sinal_q, sem_sinal_d;
    logic [31:0] endereco_q, endereco_d;
    logic        erro_q, erro_d;
    logic [31:0] resp_dados_q, resp_dados_d;
    logic [31:0] buffer_q, buffer_d;

    logic        aceita;
    logic        erro_req;
    logic [7:0]  byte_lido;
    logic [15:0] meia_lida;
    logic [31:0] lido_ext;
    logic [31:0] mesclado;

    assign bus.req_pronto   = reset_n & (estado_q == StOcioso);
    assign bus.mem_ler      = reset_n & (estado_q == StLeitura);
    assign bus.mem_escrever = reset_n & (estado_q == StEscrita);
    assign bus.mem_endereco = (bus.mem_ler | bus.mem_escrever) ?
                              {endereco_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_dados_escrita = buffer_q;
    assign bus.resp_valido  = (estado_q == StResposta);
    assign bus.resp_erro    = erro_q & (estado_q == StResposta);
    assign bus.resp_dados   = resp_dados_q;

    assign aceita = bus.req_valido & bus.req_pronto;

    always_comb begin
        erro_req = 1'b0;
        unique case (bus.req_tamanho)
            2'b00:   erro_req = 1'b0;
            2'b01:   erro_req = bus.req_endereco[0];
            2'b10:   erro_req = |bus.req_endereco[1:0];
            default: erro_req = 1'b1;
        endcase
        if ({2'b00, bus.req_endereco[31:2]} >= PALAVRAS) erro_req = 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    // The buffer still holds req_dados from the accept edge during LEITURA.
    always_comb begin
        byte_lido = bus.mem_dados_lidos[{endereco_q[1:0], 3'b000} +: 8];
        meia_lida = bus.mem_dados_lidos[{endereco_q[1], 4'b0000} +: 16];
        unique case (tamanho_q)
            2'b00:   lido_ext = sem_sinal_q ? {24'h0, byte_lido} : {{24{byte_lido[7]}}, byte_lido};
            2'b01:   lido_ext = sem_sinal_q ? {16'h0, meia_lida} : {{16{meia_lida[15]}}, meia_lida};
            default: lido_ext = bus.mem_dados_lidos;
        endcase
        mesclado = bus.mem_dados_lidos;
        if (tamanho_q == 2'b00) begin
            mesclado[{endereco_q[1:0], 3'b000} +: 8] = buffer_q[7:0];
        end else begin
            mesclado[{endereco_q[1], 4'b0000} +: 16] = buffer_q[15:0];
        end
    end

    always_comb begin
        estado_d     = estado_q;
        escrita_d    = escrita_q;
        tamanho_d    = tamanho_q;
        sem_sinal_d  = sem_sinal_q;
        endereco_d   = endereco_q;
        erro_d       = erro_q;
        resp_dados_d = resp_dados_q;
        buffer_d     = buffer_q;
        unique case (estado_q)
            StOcioso: begin
                if (aceita) begin
                    escrita_d    = bus.req_escrita;
                    tamanho_d    = bus.req_tamanho;
                    sem_sinal_d  = bus.req_sem_sinal;
                    endereco_d   = bus.req_endereco;
                    erro_d       = erro_req;
                    resp_dados_d = 32'h0;
                    buffer_d     = bus.req_dados;
                    if (erro_req) begin
                        estado_d = StResposta;
                    end else if (bus.req_escrita && bus.req_tamanho == 2'b10) begin
                        estado_d = StEscrita;
                    end else begin
                        estado_d = StLeitura;
                    end
                end
            end
            StLeitura: begin
                if (escrita_q) begin
                    buffer_d = mesclado;
                    estado_d = StEscrita;
                end else begin
                    resp_dados_d = lido_ext;
                    estado_d     = StResposta;
                end
            end
            StEscrita:  estado_d = StResposta;
            StResposta: estado_d = StOcioso;
            default:    estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q     <= StOcioso;
            escrita_q    <= 1'b0;
            tamanho_q    <= 2'b00;
            sem_sinal_q  <= 1'b0;
            endereco_q   <= 32'h0;
            erro_q       <= 1'b0;
            resp_dados_q <= 32'h0;
            buffer_q     <= 32'h0;
        end else begin
            estado_q     <= estado_d;
            escrita_q    <= escrita_d;
            tamanho_q    <= tamanho_d;
            sem_sinal_q  <= sem_sinal_d;
            endereco_q   <= endereco_d;
            erro_q       <= erro_d;
            resp_dados_q <= resp_dados_d;
            buffer_q     <= buffer_d;
        end
    end
endmodule

// File: tb/tb_unidade_load_store.sv
// Bench for unidade_load_store: directed vector table, reset corner sequences,
// and random requests scored against a byte-array reference model.
module tb_unidade_load_store;
    localparam int unsigned PALAVRAS = 513;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    unidade_load_store_if bus ();

    unidade_load_store #(.PALAVRAS(PALAVRAS)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory behaving like memoriaDeDados: combinational read, negedge write.
    logic [31:0] tb_mem [0:PALAVRAS-1] = '{default: 32'h0};
    assign bus.mem_dados_lidos = (bus.mem_endereco[31:2] < PALAVRAS) ?
                                 tb_mem[bus.mem_endereco[31:2]] : 32'h0;
    always @(negedge clock) begin
        if (bus.mem_escrever && bus.mem_endereco[31:2] < PALAVRAS)
            tb_mem[bus.mem_endereco[31:2]] <= bus.mem_dados_escrita;
    end

    // Reference model state: one entry per byte address.
    logic [7:0] ref_mem [0:PALAVRAS*4-1] = '{default: 8'h0};

    typedef struct {
        logic        esc;
        logic [1:0]  tam;
        logic        uns;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e_dados;
        logic        e_erro;
        int          e_lat;
    } vetor_t;

    vetor_t tab [18];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nome, got, exp);
        end
    endtask

    task automatic ref_req(input logic esc, input logic [1:0] tam, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic re, output int lat,
                           output int nl, output int ne);
        int n;
        logic [31:0] v;
        n  = (tam == 2'd0) ? 1 : (tam == 2'd1) ? 2 : 4;
        re = (tam == 2'd3) || (a % n != 0) || ((a >> 2) >= PALAVRAS);
        rd = 32'h0;
        if (!re) begin
            if (esc) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                rd = v;
            end
        end
        lat = re ? 1 : (esc && n < 4) ? 3 : 2;
        nl  = (!re && (!esc || n < 4)) ? 1 : 0;
        ne  = (!re && esc) ? 1 : 0;
    endtask

    task automatic do_req(input logic esc, input logic [1:0] tam, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic re, output int lat,
                          output int nl, output int ne, output int viol, output logic ok);
        int w;
        ok = 1'b0; rd = 32'h0; re = 1'b0; lat = 0; nl = 0; ne = 0; viol = 0; w = 0;
        @(negedge clock);
        while (!bus.req_pronto && w < 10) begin
            @(negedge clock);
            w++;
        end
        if (!bus.req_pronto) return;
        bus.req_escrita   = esc;
        bus.req_tamanho   = tam;
        bus.req_sem_sinal = uns;
        bus.req_endereco  = a;
        bus.req_dados     = d;
        bus.req_valido    = 1'b1;
        @(posedge clock);
        #1 bus.req_valido = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (bus.mem_ler) nl++;
            if (bus.mem_escrever) ne++;
            if (bus.mem_ler && bus.mem_escrever) viol++;
            if ((bus.mem_ler || bus.mem_escrever) && bus.mem_endereco !== {a[31:2], 2'b00})
                viol++;
            if (bus.resp_valido) begin
                lat = c;
                rd  = bus.resp_dados;
                re  = bus.resp_erro;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply(input string nome, input logic esc, input logic [1:0] tam,
                         input logic uns, input logic [31:0] a, input logic [31:0] d,
                         input logic usa_tab, input logic [31:0] t_dados, input logic t_erro,
                         input int t_lat);
        logic [31:0] m_dados, g_dados;
        logic        m_erro, g_erro, ok;
        int          m_lat, m_nl, m_ne, g_lat, g_nl, g_ne, viol;
        ref_req(esc, tam, uns, a, d, m_dados, m_erro, m_lat, m_nl, m_ne);
        do_req(esc, tam, uns, a, d, g_dados, g_erro, g_lat, g_nl, g_ne, viol, ok);
        chk({nome, ".resposta"}, 32'(ok), 32'd1);
        if (ok) begin
            if (usa_tab) begin
                chk({nome, ".dados"}, g_dados, t_dados);
                chk({nome, ".erro"}, 32'(g_erro), 32'(t_erro));
                chk({nome, ".latencia"}, 32'(g_lat), 32'(t_lat));
            end else begin
                chk({nome, ".dados"}, g_dados, m_dados);
                chk({nome, ".erro"}, 32'(g_erro), 32'(m_erro));
                chk({nome, ".latencia"}, 32'(g_lat), 32'(m_lat));
            end
            chk({nome, ".ciclos_ler"}, 32'(g_nl), 32'(m_nl));
            chk({nome, ".ciclos_escrever"}, 32'(g_ne), 32'(m_ne));
            chk({nome, ".regras_barramento"}, 32'(viol), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, d, exp;
        logic [1:0]  tam;
        int          r, vivos;

        //             esc   tam    uns   addr        data          exp_dados     err   lat
        tab[0]  = '{1'b1, 2'b10, 1'b0, 32'h4,   32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        tab[1]  = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'hDEADBEEF, 1'b0, 2};
        tab[2]  = '{1'b1, 2'b00, 1'b0, 32'h5,   32'h000000AA, 32'h00000000, 1'b0, 3};
        tab[3]  = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'hDEADAAEF, 1'b0, 2};
        tab[4]  = '{1'b0, 2'b00, 1'b0, 32'h5,   32'h0,        32'hFFFFFFAA, 1'b0, 2};
        tab[5]  = '{1'b0, 2'b00, 1'b1, 32'h5,   32'h0,        32'h000000AA, 1'b0, 2};
        tab[6]  = '{1'b1, 2'b01, 1'b0, 32'h6,   32'h00001234, 32'h00000000, 1'b0, 3};
        tab[7]  = '{1'b0, 2'b01, 1'b0, 32'h6,   32'h0,        32'h00001234, 1'b0, 2};
        tab[8]  = '{1'b1, 2'b01, 1'b0, 32'h6,   32'h00008001, 32'h00000000, 1'b0, 3};
        tab[9]  = '{1'b0, 2'b01, 1'b0, 32'h6,   32'h0,        32'hFFFF8001, 1'b0, 2};
        tab[10] = '{1'b0, 2'b01, 1'b1, 32'h6,   32'h0,        32'h00008001, 1'b0, 2};
        tab[11] = '{1'b0, 2'b10, 1'b0, 32'h2,   32'h0,        32'h00000000, 1'b1, 1};
        tab[12] = '{1'b1, 2'b01, 1'b0, 32'h3,   32'h0000FFFF, 32'h00000000, 1'b1, 1};
        tab[13] = '{1'b1, 2'b11, 1'b0, 32'h4,   32'h11111111, 32'h00000000, 1'b1, 1};
        tab[14] = '{1'b0, 2'b10, 1'b0, 32'h804, 32'h0,        32'h00000000, 1'b1, 1};
        tab[15] = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'h8001AAEF, 1'b0, 2};
        tab[16] = '{1'b1, 2'b10, 1'b0, 32'h800, 32'h0BADF00D, 32'h00000000, 1'b0, 2};
        tab[17] = '{1'b0, 2'b10, 1'b0, 32'h800, 32'h0,        32'h0BADF00D, 1'b0, 2};

        bus.req_escrita   = 1'b0;
        bus.req_tamanho   = 2'b00;
        bus.req_sem_sinal = 1'b0;
        bus.req_endereco  = 32'h0;
        bus.req_dados     = 32'h0;
        bus.req_valido    = 1'b1;
        reset_n           = 1'b0;

        // Reset held with a pending request: nothing may move.
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset.req_pronto", 32'(bus.req_pronto), 32'd0);
            chk("reset.resp_valido", 32'(bus.resp_valido), 32'd0);
            chk("reset.mem_ler", 32'(bus.mem_ler), 32'd0);
            chk("reset.mem_escrever", 32'(bus.mem_escrever), 32'd0);
        end
        reset_n        = 1'b1;
        bus.req_valido = 1'b0;
        @(negedge clock);
        chk("reset.pronto_apos", 32'(bus.req_pronto), 32'd1);

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vetor%0d", i), tab[i].esc, tab[i].tam, tab[i].uns, tab[i].a,
                  tab[i].d, 1'b1, tab[i].e_dados, tab[i].e_erro, tab[i].e_lat);
        end
        chk("mem.palavra1", tb_mem[1], 32'h8001AAEF);
        chk("mem.palavra512", tb_mem[512], 32'h0BADF00D);

        // Reset asserted during ESCRITA of an RMW byte store.
        @(negedge clock);
        bus.req_escrita   = 1'b1;
        bus.req_tamanho   = 2'b00;
        bus.req_sem_sinal = 1'b0;
        bus.req_endereco  = 32'h5;
        bus.req_dados     = 32'h55;
        bus.req_valido    = 1'b1;
        @(posedge clock);
        #1 bus.req_valido = 1'b0;
        @(negedge clock);
        chk("abort.mem_ler", 32'(bus.mem_ler), 32'd1);
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("abort.mem_escrever", 32'(bus.mem_escrever), 32'd0);
        chk("abort.resp_valido0", 32'(bus.resp_valido), 32'd0);
        @(negedge clock);
        chk("abort.resp_valido1", 32'(bus.resp_valido), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort.req_pronto", 32'(bus.req_pronto), 32'd1);
        chk("abort.resp_valido2", 32'(bus.resp_valido), 32'd0);
        chk("abort.palavra1", tb_mem[1], 32'h8001AAEF);
        apply("abort.lw", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 32'h8001AAEF, 1'b0, 2);

        // Random traffic near the bottom and the top of the address range.
        for (int i = 0; i < 150; i++) begin
            r   = $urandom_range(0, 15);
            tam = (r == 0) ? 2'b11 : 2'(r % 3);
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(508, 516)) * 4;
            else a = 32'($urandom_range(0, 15)) * 4;
            a = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) a = 32'hFFFFFFF0;
            d = $urandom;
            apply($sformatf("aleat%0d", i), 1'($urandom_range(0, 1)), tam,
                  1'($urandom_range(0, 1)), a, d, 1'b0, 32'h0, 1'b0, 0);
        end

        vivos = 0;
        for (int w = 0; w < int'(PALAVRAS); w++) begin
            if (w < 16 || w >= 508) begin
                exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
                chk($sformatf("mem.final%0d", w), tb_mem[w], exp);
                vivos++;
            end
        end
        chk("mem.final_contagem", 32'(vivos), 32'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
